// File: rtl/game_pkg.sv
// Shared definitions for the memory game: playback sequencer states and
// the default data/address widths used by the controller and pattern RAM.
package game_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHOW  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } player_state_t;

endpackage

// File: rtl/dwell_timer.sv
// Counts tick strobes up to a limit and flags the strobe that reaches it.
// Held at zero while clear is high, so it restarts cleanly on every phase.
module dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] dwell;

  assign expire = ~clear & tick & (dwell == limit - 1'b1);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      dwell <= '0;
    end else if (tick) begin
      dwell <= expire ? '0 : dwell + 1'b1;
    end
  end

endmodule

// File: rtl/seq_player.sv
// Plays the stored pattern (elements 0..round) on the LEDs, each element lit
// for ON_TICKS ticks and followed by OFF_TICKS blank ticks, then holds done.
module seq_player
  import game_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 1,
  parameter int CNT_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              tick,
  input  logic [ADDR_W-1:0] round,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] leds,
  output logic              busy,
  output logic              done
);

  player_state_t     state, state_n;
  logic [DATA_W-1:0] leds_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W-1:0] rnd, rnd_n;
  logic              en_q;
  logic              start;
  logic              timer_clear;
  logic              expire;
  logic [CNT_W-1:0]  limit;

  assign start       = en & ~en_q;
  assign timer_clear = !((state == SHOW) || (state == GAP));
  assign limit       = (state == SHOW) ? CNT_W'(ON_TICKS) : CNT_W'(OFF_TICKS);
  assign busy        = (state == FETCH) || (state == SHOW) || (state == GAP);
  assign done        = (state == DONE);

  dwell_timer #(.CNT_W(CNT_W)) u_dwell (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .tick   (tick),
    .limit  (limit),
    .expire (expire)
  );

  // Sampled even during reset so an enable held across reset cannot
  // masquerade as a fresh rising edge afterwards.
  always_ff @(posedge clock) begin
    en_q <= en;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      leds    <= '0;
      rd_addr <= '0;
      idx     <= '0;
      rnd     <= '0;
    end else begin
      state   <= state_n;
      leds    <= leds_n;
      rd_addr <= rd_addr_n;
      idx     <= idx_n;
      rnd     <= rnd_n;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves a signal unassigned and infers a latch.
    state_n   = state;
    leds_n    = leds;
    rd_addr_n = rd_addr;
    idx_n     = idx;
    rnd_n     = rnd;

    case (state)
      IDLE: begin
        leds_n = '0;
        if (start) begin
          rnd_n     = round;
          idx_n     = '0;
          rd_addr_n = '0;
          state_n   = FETCH;
        end
      end
      FETCH: begin
        if (!en) begin
          state_n = IDLE;
          leds_n  = '0;
        end else begin
          state_n = SHOW;
          leds_n  = rd_data;
        end
      end
      SHOW: begin
        if (!en) begin
          state_n = IDLE;
          leds_n  = '0;
        end else if (expire) begin
          state_n = GAP;
          leds_n  = '0;
        end
      end
      GAP: begin
        if (!en) begin
          state_n = IDLE;
          leds_n  = '0;
        end else if (expire) begin
          if (idx == rnd) begin
            state_n = DONE;
          end else begin
            idx_n     = idx + 1'b1;
            rd_addr_n = idx + 1'b1;
            state_n   = FETCH;
          end
        end
      end
      DONE: begin
        leds_n = '0;
        if (!en) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        leds_n  = '0;
      end
    endcase
  end

endmodule
